// File: rtl/seven_segment_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_arbiter_if
// Description : Source request bundle and display/grant return path for the
//               seven-segment display arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_segment_arbiter_if #(
    parameter int NUM_SRC = 4
) ();
    logic [14*NUM_SRC-1:0] src_value;
    logic [NUM_SRC-1:0]    src_decimal;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_urgent;
    logic [13:0]           display_value;
    logic                  show_decimal;
    logic                  grant_valid;
    logic [2:0]            grant_idx;
    logic [NUM_SRC-1:0]    grant_onehot;

    modport master (
        output src_value, src_decimal, src_valid, src_urgent,
        input  display_value, show_decimal, grant_valid, grant_idx, grant_onehot
    );

    modport slave (
        input  src_value, src_decimal, src_valid, src_urgent,
        output display_value, show_decimal, grant_valid, grant_idx, grant_onehot
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_arbiter
// Description : Round-robin time-sharing of one 4-digit display among up to
//               8 sources, with urgent preemption and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_arbiter #(
    parameter int          NUM_SRC      = 4,
    parameter logic [31:0] DWELL_CYCLES = 32'd50000000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    seven_segment_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWELL  = 2'd1,
        ST_URGENT = 2'd2
    } state_t;

    localparam logic [31:0] c_dwell_last = DWELL_CYCLES - 32'd1;
    localparam logic [2:0]  c_last_idx   = 3'(NUM_SRC - 1);
    localparam logic [13:0] c_sat_max    = 14'd9999;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_timer, w_timer_nxt;
    logic [2:0]  r_rr_ptr, w_rr_nxt;
    logic [2:0]  r_grant, w_grant_nxt;

    logic [13:0]        r_display;
    logic               r_decimal;
    logic               r_grant_valid;
    logic [NUM_SRC-1:0] r_onehot;

    // Sources are padded to 8 so every index search uses a fixed 3-bit index.
    logic [13:0] w_val [8];
    logic [7:0]  w_valid8, w_urgent8, w_dec8, w_eu8, w_onehot8;
    logic        w_any_eu, w_any_valid;
    logic [2:0]  w_lowest_eu, w_rr_pick, w_after_grant;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_src
            if (gi < NUM_SRC) begin : g_present
                assign w_val[gi]     = bus.src_value[14*gi +: 14];
                assign w_valid8[gi]  = bus.src_valid[gi];
                assign w_urgent8[gi] = bus.src_urgent[gi];
                assign w_dec8[gi]    = bus.src_decimal[gi];
            end else begin : g_absent
                assign w_val[gi]     = 14'd0;
                assign w_valid8[gi]  = 1'b0;
                assign w_urgent8[gi] = 1'b0;
                assign w_dec8[gi]    = 1'b0;
            end
        end
    endgenerate

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == c_last_idx) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [2:0] rr_search(input logic [2:0] start, input logic [7:0] valid);
        logic [2:0] pick;
        logic       found;
        logic [3:0] idx;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, start} + 4'(k);
            if (idx >= 4'(NUM_SRC)) idx = idx - 4'(NUM_SRC);
            if (!found && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [13:0] saturate(input logic [13:0] v);
        return (v > c_sat_max) ? c_sat_max : v;
    endfunction

    always_comb begin
        w_lowest_eu = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_eu8[i]) w_lowest_eu = 3'(i);
        end
    end

    assign w_eu8         = w_urgent8 & w_valid8;
    assign w_any_eu      = |w_eu8;
    assign w_any_valid   = |w_valid8;
    assign w_rr_pick     = rr_search(r_rr_ptr, w_valid8);
    assign w_after_grant = rr_search(next_idx(r_grant), w_valid8);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_timer_nxt = r_timer;
        w_rr_nxt    = r_rr_ptr;
        // Urgent preemption wins in every state.
        if (w_any_eu) begin
            w_state_nxt = ST_URGENT;
            w_grant_nxt = w_lowest_eu;
            w_timer_nxt = 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        w_state_nxt = ST_DWELL;
                        w_grant_nxt = w_rr_pick;
                        w_timer_nxt = 32'd0;
                    end
                end
                ST_DWELL: begin
                    w_timer_nxt = r_timer + 32'd1;
                    if ((r_timer == c_dwell_last) || !w_valid8[r_grant]) begin
                        w_timer_nxt = 32'd0;
                        if (w_any_valid) begin
                            w_grant_nxt = w_after_grant;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_rr_nxt    = next_idx(r_grant);
                        end
                    end
                end
                ST_URGENT: begin
                    w_timer_nxt = 32'd0;
                    if (w_any_valid) begin
                        w_state_nxt = ST_DWELL;
                        w_grant_nxt = w_after_grant;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = next_idx(r_grant);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_onehot8 = 8'd1 << w_grant_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= 32'd0;
            r_rr_ptr      <= 3'd0;
            r_grant       <= 3'd0;
            r_display     <= 14'd0;
            r_decimal     <= 1'b0;
            r_grant_valid <= 1'b0;
            r_onehot      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= (w_state_nxt != ST_IDLE);
            r_onehot      <= (w_state_nxt != ST_IDLE) ? w_onehot8[NUM_SRC-1:0] : '0;
            // Display holds its last content while nobody owns it.
            if (w_state_nxt != ST_IDLE) begin
                r_display <= saturate(w_val[w_grant_nxt]);
                r_decimal <= w_dec8[w_grant_nxt];
            end
        end
    end

    assign bus.display_value = r_display;
    assign bus.show_decimal  = r_decimal;
    assign bus.grant_valid   = r_grant_valid;
    assign bus.grant_idx     = r_grant;
    assign bus.grant_onehot  = r_onehot;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_arbiter
// Description : Directed plus randomized bench against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_arbiter;
    localparam int N  = 4;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    seven_segment_arbiter_if #(.NUM_SRC(N)) bus ();

    seven_segment_arbiter #(
        .NUM_SRC      (N),
        .DWELL_CYCLES (32'(DW))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: mode 0 = nobody, 1 = rotating owner, 2 = urgent owner.
    int          m_mode, m_owner, m_held, m_rr;
    logic [13:0] m_disp;
    logic        m_dec;

    function automatic int first_valid_from(input int s, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_held = 0; m_rr = 0; m_disp = 14'd0; m_dec = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] v, eu;
        int nv, lo;
        logic [13:0] raw;
        v  = bus.src_valid;
        eu = bus.src_urgent & bus.src_valid;
        lo = -1;
        for (int i = N - 1; i >= 0; i--) if (eu[i]) lo = i;
        if (lo >= 0) begin
            m_mode = 2; m_owner = lo; m_held = 0;
        end else if (m_mode == 0) begin
            nv = first_valid_from(m_rr, v);
            if (nv >= 0) begin m_mode = 1; m_owner = nv; m_held = 0; end
        end else begin
            m_held = m_held + 1;
            if (m_mode == 2 || m_held == DW || !v[m_owner]) begin
                nv = first_valid_from(m_owner + 1, v);
                if (nv < 0) begin m_rr = (m_owner + 1) % N; m_mode = 0; end
                else begin m_mode = 1; m_owner = nv; m_held = 0; end
            end
        end
        if (m_mode != 0) begin
            raw    = bus.src_value[14*m_owner +: 14];
            m_disp = (int'(raw) > 9999) ? 14'd9999 : raw;
            m_dec  = bus.src_decimal[m_owner];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic compare_all();
        check("grant_valid", 32'(bus.grant_valid), 32'(m_mode != 0));
        check("grant_onehot", 32'(bus.grant_onehot), (m_mode != 0) ? (32'd1 << m_owner) : 32'd0);
        check("display_value", 32'(bus.display_value), 32'(m_disp));
        check("show_decimal", 32'(bus.show_decimal), 32'(m_dec));
        if (m_mode != 0) check("grant_idx", 32'(bus.grant_idx), 32'(m_owner));
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic set_val(input int i, input int v);
        bus.src_value[14*i +: 14] = 14'(v);
    endtask

    initial begin
        rst             = 1'b1;
        bus.src_value   = '0;
        bus.src_decimal = '0;
        bus.src_valid   = '0;
        bus.src_urgent  = '0;
        model_reset();
        #12;
        rst = 1'b0;
        compare_all();
        check("reset_grant_idx", 32'(bus.grant_idx), 32'd0);

        // Full rotation with four valid sources.
        set_val(0, 11); set_val(1, 22); set_val(2, 33); set_val(3, 44);
        bus.src_decimal = 4'b0101;
        bus.src_valid   = 4'b1111;
        tick(1);
        check("first_grant_is_0", 32'(bus.grant_idx), 32'd0);
        tick(42);

        // Single oversized source: saturation and self re-grant.
        bus.src_valid = 4'b0001;
        set_val(0, 12000);
        tick(25);
        check("saturated_value", 32'(bus.display_value), 32'd9999);

        // Urgent preemption of a rotation, then resume after it with wrap.
        bus.src_valid = 4'b1111;
        tick(14);
        bus.src_urgent = 4'b1000;
        tick(3);
        check("urgent3_owner", 32'(bus.grant_idx), 32'd3);
        bus.src_urgent = 4'b0000;
        tick(2);

        // Concurrent urgents, lowest index first; urgent without valid ignored.
        bus.src_urgent = 4'b0101;
        tick(2);
        bus.src_urgent = 4'b0100;
        tick(2);
        bus.src_valid  = 4'b1101;
        bus.src_urgent = 4'b0110;
        tick(2);
        check("urgent_masked", 32'(bus.grant_idx), 32'd2);
        bus.src_urgent = 4'b0000;
        bus.src_valid  = 4'b1111;
        tick(3);

        // Granted source drops out, then everyone drops out.
        while (bus.grant_idx != 3'd2 && n_checks < 2000) tick(1);
        bus.src_valid = 4'b1011;
        tick(4);
        bus.src_valid = 4'b0000;
        tick(4);
        bus.src_valid = 4'b1111;
        tick(5);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst_idx", 32'(bus.grant_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check("post_rst_grant", 32'(bus.grant_idx), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bus.src_valid = 4'($urandom);
            bus.src_urgent = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) bus.src_urgent[i] = 1'b1;
            end
            set_val($urandom_range(0, N - 1), $urandom_range(0, 16383));
            bus.src_decimal = 4'($urandom);
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
